decoder_rr_arbiter: RTL and testbench
=====================================

# decoder_rr_arbiter

Registered 8-way round-robin arbiter that shares one 3-to-8 active-low select decoder among eight requesters. It sits directly in front of the decoder. It drives the decoder's select inputs {A, B, C} and the active-high enable `en`, and also presents the same one-hot active-low grant vector on `gnt_n`, so requesters and the decoder always agree on the owner. Ownership changes pass through a mandatory one-cycle dead cycle, so two grants are never active together.

## Interface
- `HOLD_MAX`, default 16: maximum number of GRANT cycles before a forced release. Legal range is 2..255. It is used only when `DRA_TIMEOUT_EN` is defined.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  8  requests, active-high. `req[i]` is requester i.
- `done`  in  1  the current owner releases the resource; sampled only in GRANT.
- `A`  out  1  select bit 2 (MSB) of the owner index.
- `B`  out  1  select bit 1 of the owner index.
- `C`  out  1  select bit 0 (LSB) of the owner index.
- `en`  out  1  decoder enable; high only in GRANT.
- `gnt_n`  out  8  active-low one-hot grant. `gnt_n[i]=0` if and only if `en=1` and owner=i. Otherwise 8'hFF.
- `timeout`  out  1  one-cycle pulse on a forced release. Tied to 0 when `DRA_TIMEOUT_EN` is undefined.

## Operation
- State machine states:
  - IDLE: no owner.
  - GRANT: owner `own[2:0]` holds the resource.
  - GAP: one dead cycle with `en=0`.
- Round-robin pointer `last[2:0]`:
  - The winner is the first set `req` bit scanning indices last+1, last+2, … modulo 8 (7 wraps to 0).
  - On every grant, `last` takes the winner index.
- IDLE:
  - If any `req` bit is set, register winner → `own` and `last`; next state GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Release condition: `done=1`, OR `req[own]=0`, OR (with `DRA_TIMEOUT_EN`) the hold counter reaches HOLD_MAX-1.
  - On release, next state GAP. Otherwise stay in GRANT.
  - Requests from other indices are ignored while in GRANT; there is no preemption.
- GAP:
  - Arbitrate exactly as in IDLE, using the `last` value updated at the previous grant.
  - Any `req` set → GRANT with the new winner. None → IDLE.
  - A requester that was just released may be re-granted only if no other index is requesting.
- Output decode, all registered from state and `own`:
  - `{A,B,C}=own`, `en=(state==GRANT)`, `gnt_n=~(en<<own)`.
  - In IDLE and GAP, `{A,B,C}` keeps the last owner value and `gnt_n=8'hFF`.
- Reset values: state IDLE, `last=3'd7` (so index 0 has first priority), `own=0`, `A=B=C=0`, `en=0`, `gnt_n=8'hFF`, `timeout=0`, hold counter 0.
- Reset has priority over every other event, including mid-GRANT: the next cycle is IDLE with all outputs at reset values.

## Timing
- Request to grant: `req` sampled high in IDLE at edge k gives `en=1` and the grant from cycle k+1. Latency is 1 cycle.
- Release to next grant: `done` sampled at edge k gives GAP (`en=0`) in cycle k+1. The next owner, if any, is granted in cycle k+2.
- Minimum spacing between two different owners is exactly one dead cycle.
- Simultaneous `done=1` and `req[own]=0`: treated as a single release.
- `done` asserted in IDLE or GAP is ignored.
- Hold counter:
  - Cleared on entry to GRANT; counts once per GRANT cycle.
  - A forced release makes GRANT last exactly HOLD_MAX cycles.
  - `timeout=1` during the following GAP cycle only.
- `req` changes during GAP affect that cycle's arbitration.

## Configuration
- `DRA_TIMEOUT_EN` defined:
  - An 8-bit hold counter and forced release at HOLD_MAX are built.
  - `timeout` pulses as described above.
- `DRA_TIMEOUT_EN` undefined:
  - No counter is built; an owner holds until `done` or until its `req` drops.
  - `timeout` is constant 0 and HOLD_MAX has no effect.

## Test plan
- Reset: assert `rst` for 2 cycles with `req=8'hFF` → `en=0`, `gnt_n=8'hFF`, `{A,B,C}=000` throughout; first grant after deassert is index 0 (`gnt_n=8'hFE`).
- Single requester: `req=8'h20` in IDLE → next cycle `en=1`, `{A,B,C}=101`, `gnt_n=8'hDF`. `done` pulse → one cycle `gnt_n=8'hFF`, then re-grant of index 5.
- Fairness: `req=8'hFF` held, `done` pulsed every 3rd GRANT cycle → owners 0,1,…,7,0 in order, a GAP cycle between each, and never two `gnt_n` bits low.
- Request drop: grant index 3, then drop `req[3]` with `req[6]=1` → GAP next cycle, then owner 6 (`gnt_n=8'hBF`).
- Timeout (`DRA_TIMEOUT_EN`, HOLD_MAX=4): `req=8'h03`, `done=0` → index 0 held exactly 4 cycles, `timeout=1` in the GAP cycle, then index 1 granted. Without the macro, index 0 is held indefinitely and `timeout` stays 0.
- Reset mid-grant: `rst` during GRANT of index 4 → next cycle IDLE, `gnt_n=8'hFF`, `last=7`; with `req=8'h11` the next grant goes to index 0.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Registered 8-way round-robin arbiter driving a 3-to-8 active-low decoder with a dead cycle between owners.
// Optional forced release after HOLD_MAX grant cycles is built when DRA_TIMEOUT_EN is defined.
module decoder_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       en,
  output logic [7:0] gnt_n,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] own_reg, own_next;
  logic [2:0] last_reg, last_next;

  logic [7:0] rot_req;
  logic [2:0] win_offs;
  logic [2:0] win;
  logic       win_valid;
  logic       hold_hit;
  logic       forced_c;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("decoder_rr_arbiter: HOLD_MAX must be in 2..255");
  end

  // rot_req[gi] is the request of the index gi+1 places after the last winner.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign rot_req[gi] = req[3'(last_reg + 3'(gi) + 3'd1)];
  end

  always_comb begin
    win_offs = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) win_offs = 3'(i);
    end
  end

  assign win_valid = |rot_req;
  assign win       = last_reg + win_offs + 3'd1;

`ifdef DRA_TIMEOUT_EN
  logic [7:0] hold_reg;

  assign hold_hit = (state_reg == GRANT) && (hold_reg == 8'(HOLD_MAX - 1));

  // Counter is zero whenever GRANT is entered because it clears on any non-staying cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= 8'd0;
    end else if (state_reg == GRANT && state_next == GRANT) begin
      hold_reg <= hold_reg + 8'd1;
    end else begin
      hold_reg <= 8'd0;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    own_next   = own_reg;
    last_next  = last_reg;
    forced_c   = 1'b0;
    case (state_reg)
      IDLE, GAP: begin
        if (win_valid) begin
          state_next = GRANT;
          own_next   = win;
          last_next  = win;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (done || !req[own_reg] || hold_hit) begin
          state_next = GAP;
        end
        forced_c = hold_hit && !done && req[own_reg];
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      own_reg   <= 3'd0;
      last_reg  <= 3'd7;
    end else begin
      state_reg <= state_next;
      own_reg   <= own_next;
      last_reg  <= last_next;
    end
  end

  // Outputs are registered from the next-state values so they line up with state_reg/own_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      A       <= 1'b0;
      B       <= 1'b0;
      C       <= 1'b0;
      en      <= 1'b0;
      gnt_n   <= 8'hFF;
      timeout <= 1'b0;
    end else begin
      A       <= own_next[2];
      B       <= own_next[1];
      C       <= own_next[0];
      en      <= (state_next == GRANT);
      gnt_n   <= ~(8'(state_next == GRANT) << own_next);
      timeout <= forced_c;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed self-checking bench for decoder_rr_arbiter; the timeout scenario follows DRA_TIMEOUT_EN.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       A, B, C, en, timeout;
  logic [7:0] gnt_n;

  int checks = 0;
  int passed = 0;

  decoder_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .A(A), .B(B), .C(C), .en(en), .gnt_n(gnt_n), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF; done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({en, gnt_n, A, B, C, timeout} !== {1'b0, 8'hFF, 3'b000, 1'b0})
        $display("FAIL reset_hold cyc%0d: en=%b gnt_n=%h abc=%b%b%b to=%b, want en=0 gnt_n=ff abc=000 to=0",
                 c, en, gnt_n, A, B, C, timeout);
      else passed++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({en, gnt_n} !== {1'b1, 8'hFE})
      $display("FAIL reset_first_grant: en=%b gnt_n=%h, want en=1 gnt_n=fe", en, gnt_n);
    else passed++;
    $display("reset: first grant gnt_n=%h", gnt_n);
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_single();
    req = 8'h20;
    tick();
    checks++;
    if ({en, A, B, C, gnt_n} !== {1'b1, 3'b101, 8'hDF})
      $display("FAIL single_grant: en=%b abc=%b%b%b gnt_n=%h, want en=1 abc=101 gnt_n=df", en, A, B, C, gnt_n);
    else passed++;
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if ({en, A, B, C, gnt_n} !== {1'b0, 3'b101, 8'hFF})
      $display("FAIL single_gap: en=%b abc=%b%b%b gnt_n=%h, want en=0 abc=101 gnt_n=ff", en, A, B, C, gnt_n);
    else passed++;
    tick();
    checks++;
    if (gnt_n !== 8'hDF)
      $display("FAIL single_regrant: gnt_n=%h, want df", gnt_n);
    else passed++;
    $display("single: regrant gnt_n=%h", gnt_n);
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    logic [7:0] exp;
    do_reset();
    req = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      exp = ~(8'h01 << (n % 8));
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (gnt_n !== exp)
          $display("FAIL fair_grant n%0d c%0d: gnt_n=%h, want %h", n, c, gnt_n, exp);
        else passed++;
        if (c == 2) done = 1'b1;
        tick();
      end
      done = 1'b0;
      checks++;
      if ({en, gnt_n} !== {1'b0, 8'hFF})
        $display("FAIL fair_gap n%0d: en=%b gnt_n=%h, want en=0 gnt_n=ff", n, en, gnt_n);
      else passed++;
      $display("fairness: owner %0d released, gap gnt_n=%h", n % 8, gnt_n);
      if (n == 8) req = 8'h00;
      tick();
    end
  endtask

  task automatic test_request_drop();
    req = 8'h08;
    tick();
    checks++;
    if (gnt_n !== 8'hF7)
      $display("FAIL drop_grant3: gnt_n=%h, want f7", gnt_n);
    else passed++;
    req = 8'h40;
    tick();
    checks++;
    if ({en, gnt_n} !== {1'b0, 8'hFF})
      $display("FAIL drop_gap: en=%b gnt_n=%h, want en=0 gnt_n=ff", en, gnt_n);
    else passed++;
    tick();
    checks++;
    if ({A, B, C, gnt_n} !== {3'b110, 8'hBF})
      $display("FAIL drop_grant6: abc=%b%b%b gnt_n=%h, want abc=110 gnt_n=bf", A, B, C, gnt_n);
    else passed++;
    $display("request_drop: new owner gnt_n=%h", gnt_n);
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h03;
    tick();
`ifdef DRA_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({gnt_n, timeout} !== {8'hFE, 1'b0})
        $display("FAIL to_hold c%0d: gnt_n=%h to=%b, want gnt_n=fe to=0", c, gnt_n, timeout);
      else passed++;
      tick();
    end
    checks++;
    if ({en, gnt_n, timeout} !== {1'b0, 8'hFF, 1'b1})
      $display("FAIL to_gap: en=%b gnt_n=%h to=%b, want en=0 gnt_n=ff to=1", en, gnt_n, timeout);
    else passed++;
    tick();
    checks++;
    if ({gnt_n, timeout} !== {8'hFD, 1'b0})
      $display("FAIL to_next: gnt_n=%h to=%b, want gnt_n=fd to=0", gnt_n, timeout);
    else passed++;
    $display("timeout: forced release, next gnt_n=%h", gnt_n);
`else
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({gnt_n, timeout} !== {8'hFE, 1'b0})
        $display("FAIL to_hold c%0d: gnt_n=%h to=%b, want gnt_n=fe to=0", c, gnt_n, timeout);
      else passed++;
      tick();
    end
    $display("timeout: disabled, index 0 held gnt_n=%h", gnt_n);
`endif
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] vec [2];
    logic [7:0] exp [2];
    vec[0] = 8'h11; exp[0] = 8'hFE;
    vec[1] = 8'h30; exp[1] = 8'hEF;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      req = 8'h10;
      tick();
      checks++;
      if (gnt_n !== 8'hEF)
        $display("FAIL rmid_grant4 k%0d: gnt_n=%h, want ef", k, gnt_n);
      else passed++;
      rst = 1'b1;
      req = vec[k];
      tick();
      checks++;
      if ({en, gnt_n, A, B, C} !== {1'b0, 8'hFF, 3'b000})
        $display("FAIL rmid_reset k%0d: en=%b gnt_n=%h abc=%b%b%b, want en=0 gnt_n=ff abc=000",
                 k, en, gnt_n, A, B, C);
      else passed++;
      rst = 1'b0;
      tick();
      checks++;
      if (gnt_n !== exp[k])
        $display("FAIL rmid_next k%0d: gnt_n=%h, want %h", k, gnt_n, exp[k]);
      else passed++;
      $display("reset_mid: req=%h next gnt_n=%h", vec[k], gnt_n);
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_done_idle();
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 8'h04;
    tick();
    checks++;
    if (gnt_n !== 8'hFB)
      $display("FAIL done_idle: gnt_n=%h, want fb", gnt_n);
    else passed++;
    req = 8'h84;
    tick();
    checks++;
    if (gnt_n !== 8'hFB)
      $display("FAIL no_preempt: gnt_n=%h, want fb", gnt_n);
    else passed++;
    $display("done_idle: owner kept gnt_n=%h", gnt_n);
    req = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_request_drop();
    test_timeout();
    test_reset_mid();
    test_done_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
